// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
// Optional ISSUE timeout is enabled with the DMEM_ARB_TIMEOUT_EN macro.
package dmem_arb_pkg;

  localparam int DW = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2,
    ERR   = 2'd3
  } state_t;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef struct packed {
    logic          we;
    logic [2:0]    funct3;
    logic [DW-1:0] addr;
    logic [DW-1:0] wdata;
  } req_t;

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane logic for a 32-bit word: byte enables, store-data shift,
// alignment check and load-data extraction/extension.
module dmem_lane_align
  import dmem_arb_pkg::*;
(
  input  logic [2:0]    i_funct3,
  input  logic [1:0]    i_addr_lo,
  input  logic [DW-1:0] i_wdata,
  input  logic [DW-1:0] i_rdata,
  output logic [3:0]    o_be,
  output logic [DW-1:0] o_wdata,
  output logic          o_misalign,
  output logic [DW-1:0] o_rdata
);

  logic [DW-1:0] w_rd_sh;

  assign w_rd_sh = i_rdata >> {i_addr_lo, 3'b000};
  assign o_wdata = i_wdata << {i_addr_lo, 3'b000};

  // Stores reuse the size encoding of the matching loads (SB=LB, SH=LH, SW=LW).
  always_comb begin
    o_be       = 4'b0000;
    o_misalign = 1'b0;
    o_rdata    = '0;
    case (i_funct3)
      F3_LB: begin
        o_be    = 4'b0001 << i_addr_lo;
        o_rdata = {{24{w_rd_sh[7]}}, w_rd_sh[7:0]};
      end
      F3_LBU: begin
        o_be    = 4'b0001 << i_addr_lo;
        o_rdata = {24'd0, w_rd_sh[7:0]};
      end
      F3_LH: begin
        o_be       = 4'b0011 << i_addr_lo;
        o_misalign = i_addr_lo[0];
        o_rdata    = {{16{w_rd_sh[15]}}, w_rd_sh[15:0]};
      end
      F3_LHU: begin
        o_be       = 4'b0011 << i_addr_lo;
        o_misalign = i_addr_lo[0];
        o_rdata    = {16'd0, w_rd_sh[15:0]};
      end
      F3_LW: begin
        o_be       = 4'b1111;
        o_misalign = (i_addr_lo != 2'b00);
        o_rdata    = i_rdata;
      end
      default: begin
        o_misalign = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing a single-port data memory between a core port (C)
// and a loader port (L). Define DMEM_ARB_TIMEOUT_EN to abort stalled accesses.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             c_valid,
  input  logic             c_we,
  input  logic [2:0]       c_funct3,
  input  logic [WIDTH-1:0] c_addr,
  input  logic [WIDTH-1:0] c_wdata,
  output logic             c_ack,
  output logic [WIDTH-1:0] c_rdata,
  output logic             c_err,
  input  logic             l_valid,
  input  logic             l_we,
  input  logic [2:0]       l_funct3,
  input  logic [WIDTH-1:0] l_addr,
  input  logic [WIDTH-1:0] l_wdata,
  output logic             l_ack,
  output logic [WIDTH-1:0] l_rdata,
  output logic             l_err,
  output logic             mem_req,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_addr,
  output logic [3:0]       mem_be,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic [WIDTH-1:0] mem_rdata,
  input  logic             mem_ack,
  output logic             busy,
  output logic             grant_id,
  output logic [1:0]       o_dbg_state
);

  // Handshake: a requester raises valid with stable fields and holds them until
  // its one-cycle ack; valid still high in the cycle after ack is a new request.
  // Memory side: mem_req is held with stable fields until mem_ack is seen.

  if (WIDTH != DW || TIMEOUT < 1) begin : g_cfg_check
    $error("dmem_arbiter: WIDTH must be 32 and TIMEOUT at least 1");
  end

  state_t        r_state;
  state_t        w_state_next;
  req_t          r_req;
  req_t          w_in_req;
  logic          r_grant;
  logic          r_last_grant;
  logic          r_err_phase;
  logic [DW-1:0] r_rdata;

  logic          w_any;
  logic          w_pick_l;
  logic [2:0]    w_al_funct3;
  logic [1:0]    w_al_addr;
  logic [DW-1:0] w_al_wdata;
  logic [3:0]    w_be;
  logic [DW-1:0] w_wdata_sh;
  logic [DW-1:0] w_rdata_ext;
  logic          w_misalign;
  logic          w_resp_ack;
  logic          w_err_ack;
  logic [DW-1:0] w_load;

  assign w_any    = c_valid | l_valid;
  assign w_pick_l = l_valid & (~c_valid | ~r_last_grant);

  always_comb begin
    w_in_req.we     = w_pick_l ? l_we     : c_we;
    w_in_req.funct3 = w_pick_l ? l_funct3 : c_funct3;
    w_in_req.addr   = w_pick_l ? l_addr   : c_addr;
    w_in_req.wdata  = w_pick_l ? l_wdata  : c_wdata;
  end

  // In IDLE the lane logic checks the incoming request; afterwards it serves
  // the registered one.
  assign w_al_funct3 = (r_state == IDLE) ? w_in_req.funct3    : r_req.funct3;
  assign w_al_addr   = (r_state == IDLE) ? w_in_req.addr[1:0] : r_req.addr[1:0];
  assign w_al_wdata  = (r_state == IDLE) ? w_in_req.wdata     : r_req.wdata;

  dmem_lane_align u_lane (
    .i_funct3   (w_al_funct3),
    .i_addr_lo  (w_al_addr),
    .i_wdata    (w_al_wdata),
    .i_rdata    (r_rdata),
    .o_be       (w_be),
    .o_wdata    (w_wdata_sh),
    .o_misalign (w_misalign),
    .o_rdata    (w_rdata_ext)
  );

`ifdef DMEM_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  logic [TW-1:0] r_tmo_cnt;
  logic          w_tmo_hit;

  assign w_tmo_hit = (r_tmo_cnt == TMO_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_tmo_cnt <= '0;
    end else if (r_state != ISSUE) begin
      r_tmo_cnt <= '0;
    end else if (!mem_ack) begin
      r_tmo_cnt <= r_tmo_cnt + TW'(1);
    end
  end
`else
  logic w_tmo_hit;
  assign w_tmo_hit = 1'b0;
`endif

  // ERR spends one settle cycle before acking so that error acks arrive with
  // the same two-cycle latency as the fastest memory access.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_any) w_state_next = w_misalign ? ERR : ISSUE;
      ISSUE: begin
        if (mem_ack)        w_state_next = RESP;
        else if (w_tmo_hit) w_state_next = ERR;
      end
      RESP:    w_state_next = IDLE;
      ERR:     if (r_err_phase) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_req        <= '0;
      r_grant      <= 1'b0;
      r_last_grant <= 1'b1;
      r_err_phase  <= 1'b0;
      r_rdata      <= '0;
    end else begin
      r_state     <= w_state_next;
      r_err_phase <= (r_state == ERR) && !r_err_phase;
      if (r_state == IDLE && w_any) begin
        r_req        <= w_in_req;
        r_grant      <= w_pick_l;
        r_last_grant <= w_pick_l;
      end
      if (r_state == ISSUE && mem_ack) begin
        r_rdata <= mem_rdata;
      end
    end
  end

  assign w_resp_ack = (r_state == RESP);
  assign w_err_ack  = (r_state == ERR) && r_err_phase;
  assign w_load     = (w_resp_ack && !r_req.we) ? w_rdata_ext : '0;

  assign c_ack   = (w_resp_ack | w_err_ack) & ~r_grant;
  assign l_ack   = (w_resp_ack | w_err_ack) &  r_grant;
  assign c_err   = w_err_ack & ~r_grant;
  assign l_err   = w_err_ack &  r_grant;
  assign c_rdata = r_grant ? '0 : w_load;
  assign l_rdata = r_grant ? w_load : '0;

  assign mem_req   = (r_state == ISSUE);
  assign mem_we    = mem_req & r_req.we;
  assign mem_addr  = mem_req ? {r_req.addr[WIDTH-1:2], 2'b00} : '0;
  assign mem_be    = mem_req ? w_be : 4'b0000;
  assign mem_wdata = (mem_req && r_req.we) ? w_wdata_sh : '0;

  assign busy        = (r_state != IDLE);
  assign grant_id    = r_grant;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: vector table of single transfers plus
// hand-written sequences for reset, arbitration, abort and timeout.
module tb_dmem_arbiter;
  import dmem_arb_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         c_valid = 0, c_we = 0;
  logic [2:0]   c_funct3 = 0;
  logic [W-1:0] c_addr = 0, c_wdata = 0;
  logic         c_ack, c_err;
  logic [W-1:0] c_rdata;
  logic         l_valid = 0, l_we = 0;
  logic [2:0]   l_funct3 = 0;
  logic [W-1:0] l_addr = 0, l_wdata = 0;
  logic         l_ack, l_err;
  logic [W-1:0] l_rdata;
  logic         mem_req, mem_we;
  logic [W-1:0] mem_addr, mem_wdata;
  logic [3:0]   mem_be;
  logic [W-1:0] mem_rdata = 0;
  logic         mem_ack = 0;
  logic         busy, grant_id;
  logic [1:0]   dbg_state;

  int n_cmp = 0;
  int n_mis = 0;
  logic [W:0] exp_q[$];

  dmem_arbiter #(.WIDTH(32), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst),
    .c_valid(c_valid), .c_we(c_we), .c_funct3(c_funct3), .c_addr(c_addr),
    .c_wdata(c_wdata), .c_ack(c_ack), .c_rdata(c_rdata), .c_err(c_err),
    .l_valid(l_valid), .l_we(l_we), .l_funct3(l_funct3), .l_addr(l_addr),
    .l_wdata(l_wdata), .l_ack(l_ack), .l_rdata(l_rdata), .l_err(l_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .busy(busy), .grant_id(grant_id), .o_dbg_state(dbg_state)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  // driver
  task automatic drive_req(input logic port, input logic v, input logic we,
                           input logic [2:0] f3, input logic [W-1:0] addr,
                           input logic [W-1:0] wdata);
    if (port) begin
      l_valid = v; l_we = we; l_funct3 = f3; l_addr = addr; l_wdata = wdata;
    end else begin
      c_valid = v; c_we = we; c_funct3 = f3; c_addr = addr; c_wdata = wdata;
    end
  endtask

  typedef struct {
    logic         port;
    logic         we;
    logic [2:0]   f3;
    logic [W-1:0] addr;
    logic [W-1:0] wdata;
    logic [W-1:0] mrdata;
    logic         err;
    logic [3:0]   be;
    logic [W-1:0] mwdata;
    logic [W-1:0] rdata;
  } vec_t;

  vec_t vecs[13];

  // One transfer on an idle arbiter; memory acks in the first mem_req cycle.
  task automatic apply_vec(input vec_t v);
    logic [W:0] e;
    exp_q.push_back({v.err, v.rdata});
    @(negedge clk);
    drive_req(v.port, 1'b1, v.we, v.f3, v.addr, v.wdata);
    @(negedge clk);
    check("c1_busy", busy, 1);
    check("c1_no_ack", c_ack | l_ack, 0);
    check("c1_grant_id", grant_id, v.port);
    if (!v.err) begin
      check("c1_mem_req", mem_req, 1);
      check("c1_mem_addr", mem_addr, {v.addr[W-1:2], 2'b00});
      check("c1_mem_be", mem_be, v.be);
      check("c1_mem_we", mem_we, v.we);
      check("c1_mem_wdata", mem_wdata, v.mwdata);
      mem_ack = 1'b1;
      mem_rdata = v.mrdata;
    end else begin
      check("c1_err_no_mem_req", mem_req, 0);
    end
    @(negedge clk);
    mem_ack = 1'b0;
    mem_rdata = '0;
    e = exp_q.pop_front();
    check("c2_ack", v.port ? l_ack : c_ack, 1);
    check("c2_other_ack", v.port ? c_ack : l_ack, 0);
    check("c2_err", v.port ? l_err : c_err, e[W]);
    check("c2_rdata", v.port ? l_rdata : c_rdata, e[W-1:0]);
    check("c2_other_rdata", v.port ? c_rdata : l_rdata, 0);
    check("c2_mem_req", mem_req, 0);
    drive_req(v.port, 1'b0, 1'b0, 3'b000, '0, '0);
    @(negedge clk);
    check("c3_idle", busy, 0);
  endtask

  initial begin
    int hi_cnt;
    int acks;
    logic p;
    logic exp_port_q[$];

    //                port we  f3      addr          wdata         mrdata        err be       mwdata        rdata
    vecs[0]  = '{1'b0, 1'b1, F3_LW,  32'h0000_0104, 32'hDEAD_BEEF, 32'h0,        1'b0, 4'b1111, 32'hDEAD_BEEF, 32'h0};
    vecs[1]  = '{1'b0, 1'b0, F3_LB,  32'h0000_0103, 32'h0,         32'h8000_0000, 1'b0, 4'b1000, 32'h0,        32'hFFFF_FF80};
    vecs[2]  = '{1'b0, 1'b0, F3_LBU, 32'h0000_0103, 32'h0,         32'h8000_0000, 1'b0, 4'b1000, 32'h0,        32'h0000_0080};
    vecs[3]  = '{1'b0, 1'b1, F3_LH,  32'h0000_0102, 32'h0000_1234, 32'h0,        1'b0, 4'b1100, 32'h1234_0000, 32'h0};
    vecs[4]  = '{1'b0, 1'b0, F3_LH,  32'h0000_0102, 32'h0,         32'h8765_4321, 1'b0, 4'b1100, 32'h0,        32'hFFFF_8765};
    vecs[5]  = '{1'b1, 1'b0, F3_LHU, 32'h0000_0200, 32'h0,         32'h8765_F00D, 1'b0, 4'b0011, 32'h0,        32'h0000_F00D};
    vecs[6]  = '{1'b1, 1'b0, F3_LW,  32'h0000_0208, 32'h0,         32'hCAFE_BABE, 1'b0, 4'b1111, 32'h0,        32'hCAFE_BABE};
    vecs[7]  = '{1'b1, 1'b1, F3_LB,  32'h0000_0205, 32'h0000_00A5, 32'h0,        1'b0, 4'b0010, 32'h0000_A500, 32'h0};
    vecs[8]  = '{1'b1, 1'b0, F3_LW,  32'h0000_0201, 32'h0,         32'h0,        1'b1, 4'b0000, 32'h0,        32'h0};
    vecs[9]  = '{1'b0, 1'b0, F3_LH,  32'h0000_0101, 32'h0,         32'h0,        1'b1, 4'b0000, 32'h0,        32'h0};
    vecs[10] = '{1'b0, 1'b0, 3'b011, 32'h0000_0100, 32'h0,         32'h0,        1'b1, 4'b0000, 32'h0,        32'h0};
    vecs[11] = '{1'b0, 1'b0, F3_LB,  32'h0000_0101, 32'h0,         32'h0000_7F00, 1'b0, 4'b0010, 32'h0,        32'h0000_007F};
    vecs[12] = '{1'b1, 1'b1, F3_LH,  32'h0000_020E, 32'hFFFF_BEEF, 32'h0,        1'b0, 4'b1100, 32'hBEEF_0000, 32'h0};

    // reset and idle
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_c_ack", c_ack, 0);
    check("rst_l_ack", l_ack, 0);
    check("rst_c_err", c_err, 0);
    check("rst_l_err", l_err, 0);
    check("rst_c_rdata", c_rdata, 0);
    check("rst_l_rdata", l_rdata, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_be", mem_be, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_busy", busy, 0);
    check("rst_grant_id", grant_id, 0);
    check("rst_state", dbg_state, IDLE);
    hi_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (mem_req || busy) hi_cnt++;
    end
    check("idle_10_cycles", hi_cnt, 0);

    // vector table
    for (int i = 0; i < 13; i++) apply_vec(vecs[i]);

    // mem_ack while idle is ignored
    @(negedge clk);
    mem_ack = 1'b1;
    mem_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    mem_ack = 1'b0;
    mem_rdata = '0;
    check("stray_ack_busy", busy, 0);
    check("stray_ack_acks", c_ack | l_ack, 0);

    // reset during ISSUE: request held, no ack, then abort
    @(negedge clk);
    drive_req(1'b0, 1'b1, 1'b0, F3_LW, 32'h0000_0400, '0);
    @(negedge clk);
    check("abort_mem_req", mem_req, 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("abort_hold_req", mem_req, 1);
      check("abort_hold_addr", mem_addr, 32'h0000_0400);
    end
    rst = 1'b1;
    @(negedge clk);
    check("abort_busy", busy, 0);
    check("abort_mem_req_drop", mem_req, 0);
    check("abort_no_ack", c_ack, 0);
    rst = 1'b0;
    drive_req(1'b0, 1'b0, 1'b0, 3'b000, '0, '0);
    acks = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (c_ack || l_ack) acks++;
    end
    check("abort_no_late_ack", acks, 0);

    // both requesters held: after reset C wins first, then strict alternation
    exp_port_q = '{1'b0, 1'b1, 1'b0, 1'b1};
    @(negedge clk);
    drive_req(1'b0, 1'b1, 1'b0, F3_LW, 32'h0000_0300, '0);
    drive_req(1'b1, 1'b1, 1'b1, F3_LW, 32'h0000_0304, 32'h0000_55AA);
    acks = 0;
    for (int cyc = 0; cyc < 40 && acks < 4; cyc++) begin
      @(negedge clk);
      if (mem_req) check("arb_mem_addr", mem_addr, grant_id ? 32'h0000_0304 : 32'h0000_0300);
      mem_ack = mem_req;
      mem_rdata = mem_req ? 32'h1111_1111 : '0;
      if (c_ack || l_ack) begin
        check("arb_single_ack", c_ack & l_ack, 0);
        p = exp_port_q.pop_front();
        check("arb_ack_port", l_ack, p);
        check("arb_grant_id", grant_id, p);
        check("arb_rdata", p ? l_rdata : c_rdata, p ? 32'h0 : 32'h1111_1111);
        acks++;
        if (acks == 4) begin
          drive_req(1'b0, 1'b0, 1'b0, 3'b000, '0, '0);
          drive_req(1'b1, 1'b0, 1'b0, 3'b000, '0, '0);
        end
      end
    end
    mem_ack = 1'b0;
    mem_rdata = '0;
    check("arb_ack_count", acks, 4);
    @(negedge clk);
    @(negedge clk);
    check("arb_idle_after", busy, 0);

`ifdef DMEM_ARB_TIMEOUT_EN
    // memory never answers: mem_req for TIMEOUT cycles, then error ack
    @(negedge clk);
    drive_req(1'b0, 1'b1, 1'b0, F3_LW, 32'h0000_0500, '0);
    hi_cnt = 0;
    acks = 0;
    for (int cyc = 0; cyc < 60 && acks == 0; cyc++) begin
      @(negedge clk);
      if (mem_req) hi_cnt++;
      if (c_ack) begin
        acks = 1;
        check("tmo_err", c_err, 1);
        check("tmo_rdata", c_rdata, 0);
      end
    end
    drive_req(1'b0, 1'b0, 1'b0, 3'b000, '0, '0);
    check("tmo_ack_seen", acks, 1);
    check("tmo_req_cycles", hi_cnt, 16);
    @(negedge clk);
    @(negedge clk);
`endif

    // recovery: a clean transfer after all of the above
    apply_vec(vecs[0]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Sequences and shares the single-port data memory between two requesters: port C (core load/store path, driven by write_en/read_en, Funct3, Mem_addr_out, RS2_data_out) and port L (program/data loader or debug).
- Round-robin arbitration, one outstanding access at a time.
- Generates byte enables and lane-shifted write data; extracts and extends load data per Funct3.
- Rejects misaligned accesses without touching memory.

Parameters:
- WIDTH, 32, data/address width; byte-lane logic is defined for 32 only.
- TIMEOUT, 16, cycles to wait for mem_ack before aborting (used only with the optional feature).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- c_valid  in  1  core request; held stable until c_ack
- c_we  in  1  1=store, 0=load
- c_funct3  in  3  RV32I load/store Funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW)
- c_addr  in  WIDTH  byte address
- c_wdata  in  WIDTH  store data, unshifted (RS2 value)
- c_ack  out  1  one-cycle completion pulse
- c_rdata  out  WIDTH  load result, valid with c_ack
- c_err  out  1  misaligned/timeout flag, valid with c_ack
- l_valid, l_we, l_funct3, l_addr, l_wdata, l_ack, l_rdata, l_err: loader port, identical to the c_ ports
- mem_req  out  1  memory request, held until mem_ack
- mem_we  out  1  write strobe
- mem_addr  out  WIDTH  word address; bits [1:0] are always 0
- mem_be  out  4  byte enables
- mem_wdata  out  WIDTH  lane-aligned write data
- mem_rdata  in  WIDTH  read word, valid with mem_ack
- mem_ack  in  1  memory completion
- busy  out  1  FSM not in IDLE
- grant_id  out  1  0=C, 1=L; port of the current or last transfer

Behaviour:
- Reset: all outputs 0; FSM=IDLE; last_grant=1, so C wins the first tie.
- FSM states: IDLE, ISSUE, RESP, ERR.
- IDLE:
  - If any valid is high, grant and register the granted port's we, funct3, addr and wdata.
  - Aligned access -> ISSUE. Misaligned access -> ERR.
  - Misaligned: halfword with addr[0]=1; word with addr[1:0]!=0.
  - Invalid funct3 (011, 110, 111) is treated as an error.
- Arbitration:
  - Only one valid -> that port is granted.
  - Both valid -> grant the port != last_grant.
  - last_grant updates when the grant is made.
- ISSUE:
  - mem_req=1 with registered fields; fields stay stable until mem_ack.
  - mem_ack=1 -> capture mem_rdata, go to RESP.
- RESP: granted port's ack=1 for exactly one cycle, err=0 -> IDLE.
- ERR: granted port's ack=1 and err=1 for one cycle; memory not accessed -> IDLE.
- Minimum latency: valid sampled at cycle 0 -> mem_req at cycle 1 -> ack at cycle 2 if mem_ack arrives at cycle 1. Error path: ack at cycle 2.
- Requester contract: valid high in the cycle after the ack is treated as a new request.
- rdata/err: zero on the non-granted port and outside ack cycles.
- Byte enables:
  - Byte: be = 1 << addr[1:0].
  - Half: be = 0011 << addr[1:0].
  - Word: be = 1111.
- Store data: mem_wdata = wdata << (8*addr[1:0]).
- Load data: byte/half extracted from lane addr[1:0].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
  - Store acks return rdata=0.
- mem_ack outside ISSUE is ignored.
- rst asserted mid-transfer:
  - Immediate return to IDLE; mem_req drops next edge.
  - No ack is issued; the pending memory access is abandoned.

Optional Feature:
- Macro DMEM_ARB_TIMEOUT_EN.
- With the macro defined:
  - A counter clears on entry to ISSUE and increments each ISSUE cycle without mem_ack.
  - Reaching TIMEOUT -> drop mem_req, go to ERR (ack with err=1, rdata=0).
  - mem_ack and timeout in the same cycle: mem_ack wins.
- Without the macro: ISSUE waits indefinitely; no counter logic is present.

Decomposition:
- Package dmem_arb_pkg:
  - typedef enum state_t {IDLE, ISSUE, RESP, ERR}.
  - Funct3 localparams F3_LB=000, F3_LH=001, F3_LW=010, F3_LBU=100, F3_LHU=101.
  - typedef for the registered request struct (we, funct3, addr, wdata).
- One natural sub-module: dmem_lane_align, purely combinational. It computes be, shifted wdata, misalign flag and extended load data from funct3/addr.

Test Plan:
- Reset then idle: all outputs 0, busy=0, mem_req stays 0 for 10 cycles.
- C SW, addr=0x104, wdata=0xDEADBEEF, mem_ack 1 cycle after mem_req -> mem_addr=0x104, be=1111, mem_wdata=0xDEADBEEF; c_ack at cycle 2, c_err=0.
- C LB, addr=0x103, mem_rdata=0x80_00_00_00 -> c_rdata=0xFFFFFF80. LBU, same setup -> 0x00000080. SH, addr=0x102, wdata=0x1234 -> be=1100, mem_wdata=0x12340000.
- c_valid and l_valid both high, held, re-requesting after each ack -> grants alternate C, L, C, L; grant_id toggles; exactly one ack per grant.
- L LW, addr=0x201 -> l_ack with l_err=1 at cycle 2; mem_req never asserted.
- With DMEM_ARB_TIMEOUT_EN, TIMEOUT=16, mem_ack tied 0 -> mem_req high 16 cycles, then c_ack with c_err=1. Also: rst during ISSUE -> busy=0 next cycle, no ack.
